// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: captures MSI/MTI/MEI, picks by priority MEI > MSI > MTI,
// and presents one request to the core over a valid/ack handshake. Optional macro: IRQ_ARBITER_SYNC_EN.
module irq_arbiter #(
  parameter int                      DATA_WIDTH       = 32,
  parameter int                      ADDRESS_BITS     = 32,
  parameter int                      NUM_EXT          = 4,
  parameter logic [ADDRESS_BITS-1:0] MSIP_ADDR        = 32'h0020_0000,
  parameter logic [ADDRESS_BITS-1:0] EXT_PENDING_ADDR = 32'h0020_0010,
  parameter logic [ADDRESS_BITS-1:0] EXT_ENABLE_ADDR  = 32'h0020_0014
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    readEnable,
  input  logic                    writeEnable,
  input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   writeData,
  output logic [DATA_WIDTH-1:0]   readData,
  input  logic                    timer_interrupt,
  input  logic [NUM_EXT-1:0]      ext_irq,
  input  logic                    mstatus_mie,
  input  logic                    mie_msie,
  input  logic                    mie_mtie,
  input  logic                    mie_meie,
  output logic                    irq_valid,
  output logic [3:0]              irq_cause,
  output logic [3:0]              irq_ext_id,
  input  logic                    irq_ack
);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || NUM_EXT < 1 || NUM_EXT > 16) begin : g_param_check
    $error("irq_arbiter: DATA_WIDTH must be 32 or 64 and NUM_EXT must be 1..16");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACKD = 2'd2;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cause_q, cause_d;
  logic [3:0]            id_q, id_d;
  logic                  msip_q, msip_d;
  logic [NUM_EXT-1:0]    pending_q, pending_d;
  logic [NUM_EXT-1:0]    enable_q, enable_d;
  logic [NUM_EXT-1:0]    hist_q, hist_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic [NUM_EXT-1:0]    ext_in;
  logic [NUM_EXT-1:0]    rise;
  logic [NUM_EXT-1:0]    wr_lane_mask;
  logic [NUM_EXT-1:0]    w1c_clear;
  logic [NUM_EXT-1:0]    ack_clear;
  logic [NUM_EXT-1:0]    ext_ready;
  logic                  sel_msip, sel_pend, sel_en;
  logic                  mei, msi, mti;
  logic                  line_ready, latched_eligible, ack_take;
  logic [3:0]            win_id;
  logic                  unused_bits;

  assign unused_bits = ^{writeData, writeByteEnable};

`ifdef IRQ_ARBITER_SYNC_EN
  logic [NUM_EXT-1:0] sync1_q, sync1_d;
  logic [NUM_EXT-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = ext_irq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign ext_in = sync2_q;
`else
  assign ext_in = ext_irq;
`endif

  always_comb begin
    sel_msip = (address == MSIP_ADDR);
    sel_pend = (address == EXT_PENDING_ADDR);
    sel_en   = (address == EXT_ENABLE_ADDR);
    for (int i = 0; i < NUM_EXT; i++) begin
      wr_lane_mask[i] = writeByteEnable[i/8];
    end
    w1c_clear = (writeEnable && sel_pend) ? (writeData[NUM_EXT-1:0] & wr_lane_mask) : '0;
  end

  // Eligibility is evaluated on registered pending/msip so a new source requests one edge later.
  always_comb begin
    ext_ready = pending_q & enable_q;
    mei = mstatus_mie & mie_meie & (|ext_ready);
    msi = mstatus_mie & mie_msie & msip_q;
    mti = mstatus_mie & mie_mtie & timer_interrupt;
    win_id = 4'd0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_ready[i]) win_id = 4'(i);
    end
    line_ready = 1'b0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (id_q == 4'(i)) line_ready = ext_ready[i];
    end
    case (cause_q)
      CAUSE_MEI: latched_eligible = mstatus_mie & mie_meie & line_ready;
      CAUSE_MSI: latched_eligible = msi;
      CAUSE_MTI: latched_eligible = mti;
      default:   latched_eligible = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    id_d     = id_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (mei) begin
          state_d = REQ;
          cause_d = CAUSE_MEI;
          id_d    = win_id;
        end else if (msi) begin
          state_d = REQ;
          cause_d = CAUSE_MSI;
          id_d    = 4'd0;
        end else if (mti) begin
          state_d = REQ;
          cause_d = CAUSE_MTI;
          id_d    = 4'd0;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d  = ACKD;
          ack_take = 1'b1;
        end else if (!latched_eligible) begin
          state_d = IDLE;
        end
      end
      ACKD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new edge in the same cycle as a clear must leave the line pending.
  always_comb begin
    hist_d = ext_in;
    rise   = ext_in & ~hist_q;
    for (int i = 0; i < NUM_EXT; i++) begin
      ack_clear[i] = ack_take && (cause_q == CAUSE_MEI) && (id_q == 4'(i));
    end
    pending_d = (pending_q & ~(w1c_clear | ack_clear)) | rise;
  end

  always_comb begin
    msip_d = msip_q;
    if (writeEnable && sel_msip && writeByteEnable[0]) msip_d = writeData[0];
    enable_d = enable_q;
    if (writeEnable && sel_en) begin
      enable_d = (enable_q & ~wr_lane_mask) | (writeData[NUM_EXT-1:0] & wr_lane_mask);
    end
    read_data_d = read_data_q;
    if (readEnable) begin
      read_data_d = '0;
      if (sel_msip)      read_data_d[0] = msip_q;
      else if (sel_pend) read_data_d[NUM_EXT-1:0] = pending_q;
      else if (sel_en)   read_data_d[NUM_EXT-1:0] = enable_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cause_q     <= 4'd0;
      id_q        <= 4'd0;
      msip_q      <= 1'b0;
      pending_q   <= '0;
      enable_q    <= '0;
      hist_q      <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      id_q        <= id_d;
      msip_q      <= msip_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      hist_q      <= hist_d;
      read_data_q <= read_data_d;
    end
  end

  assign readData   = read_data_q;
  assign irq_valid  = (state_q == REQ);
  assign irq_cause  = cause_q;
  assign irq_ext_id = id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_irq_arbiter;

  localparam logic [31:0] A_MSIP = 32'h0020_0000;
  localparam logic [31:0] A_PEND = 32'h0020_0010;
  localparam logic [31:0] A_EN   = 32'h0020_0014;
  localparam logic [31:0] A_BAD  = 32'h0020_0008;
`ifdef IRQ_ARBITER_SYNC_EN
  localparam int SET_EDGE = 3;
`else
  localparam int SET_EDGE = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        readEnable = 1'b0;
  logic        writeEnable = 1'b0;
  logic [3:0]  writeByteEnable = 4'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] writeData = 32'h0;
  logic [31:0] readData;
  logic        timer_interrupt = 1'b0;
  logic [3:0]  ext_irq = 4'h0;
  logic        mstatus_mie = 1'b0;
  logic        mie_msie = 1'b0;
  logic        mie_mtie = 1'b0;
  logic        mie_meie = 1'b0;
  logic        irq_valid;
  logic [3:0]  irq_cause;
  logic [3:0]  irq_ext_id;
  logic        irq_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  irq_arbiter dut (
    .clock(clock), .reset(reset), .readEnable(readEnable), .writeEnable(writeEnable),
    .writeByteEnable(writeByteEnable), .address(address), .writeData(writeData),
    .readData(readData), .timer_interrupt(timer_interrupt), .ext_irq(ext_irq),
    .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .irq_valid(irq_valid), .irq_cause(irq_cause), .irq_ext_id(irq_ext_id), .irq_ack(irq_ack)
  );

  // Reference state: a request flag, a one-cycle post-ack gap, and the software-visible registers.
  logic        m_valid = 1'b0, m_gap = 1'b0, m_msip = 1'b0;
  logic [3:0]  m_cause = 4'h0, m_id = 4'h0, m_pend = 4'h0, m_en = 4'h0, m_prev = 4'h0;
  logic [31:0] m_rd = 32'h0;
`ifdef IRQ_ARBITER_SYNC_EN
  logic [3:0]  m_s1 = 4'h0, m_s2 = 4'h0;
`endif

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock) begin : ref_model
    logic [3:0] ext_now, ready, clr, nc, nid;
    logic       mei_ok, msi_ok, mti_ok, still, nv, ngap;
    if (reset) begin
      m_valid = 0; m_gap = 0; m_cause = 0; m_id = 0; m_msip = 0;
      m_pend = 0; m_en = 0; m_prev = 0; m_rd = 0;
`ifdef IRQ_ARBITER_SYNC_EN
      m_s1 = 0; m_s2 = 0;
`endif
    end else begin
`ifdef IRQ_ARBITER_SYNC_EN
      ext_now = m_s2; m_s2 = m_s1; m_s1 = ext_irq;
`else
      ext_now = ext_irq;
`endif
      ready  = m_pend & m_en;
      mei_ok = mstatus_mie && mie_meie && (ready != 0);
      msi_ok = mstatus_mie && mie_msie && m_msip;
      mti_ok = mstatus_mie && mie_mtie && timer_interrupt;
      nv = m_valid; ngap = 0; nc = m_cause; nid = m_id; clr = 0; still = 0;
      if (m_valid) begin
        if (m_cause == 4'd11) still = mstatus_mie && mie_meie && ready[m_id];
        else if (m_cause == 4'd3) still = msi_ok;
        else if (m_cause == 4'd7) still = mti_ok;
        if (irq_ack) begin
          nv = 0; ngap = 1;
          if (m_cause == 4'd11) clr[m_id] = 1;
        end else if (!still) nv = 0;
      end else if (!m_gap) begin
        if (mei_ok) begin nv = 1; nc = 4'd11; nid = 4'(lowest(ready)); end
        else if (msi_ok) begin nv = 1; nc = 4'd3; nid = 0; end
        else if (mti_ok) begin nv = 1; nc = 4'd7; nid = 0; end
      end
      if (readEnable) begin
        if (address == A_MSIP) m_rd = {31'b0, m_msip};
        else if (address == A_PEND) m_rd = {28'b0, m_pend};
        else if (address == A_EN) m_rd = {28'b0, m_en};
        else m_rd = 0;
      end
      if (writeEnable) begin
        if (address == A_MSIP && writeByteEnable[0]) m_msip = writeData[0];
        for (int i = 0; i < 4; i++) begin
          if (address == A_EN && writeByteEnable[i/8]) m_en[i] = writeData[i];
          if (address == A_PEND && writeByteEnable[i/8] && writeData[i]) clr[i] = 1;
        end
      end
      m_pend  = (m_pend & ~clr) | (ext_now & ~m_prev);
      m_prev  = ext_now;
      m_valid = nv; m_gap = ngap; m_cause = nc; m_id = nid;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge clock); #2;
      checkOutput("model irq_valid", 32'(irq_valid), 32'(m_valid));
      checkOutput("model readData", readData, m_rd);
      if (m_valid) begin
        checkOutput("model irq_cause", 32'(irq_cause), 32'(m_cause));
        checkOutput("model irq_ext_id", 32'(irq_ext_id), 32'(m_id));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writeData = d; writeByteEnable = be; writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    address = a; readEnable = 1'b1;
    tick();
    d = readData;
    readEnable = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!irq_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(irq_valid), 32'd1);
  endtask

  task automatic ackOnce();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic applyStimulus();
    int r;
    reset       = ($urandom_range(0, 299) == 0);
    mstatus_mie = ($urandom_range(0, 15) != 0);
    mie_msie    = ($urandom_range(0, 9) != 0);
    mie_mtie    = ($urandom_range(0, 9) != 0);
    mie_meie    = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 7) == 0) timer_interrupt = ~timer_interrupt;
    for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) ext_irq[i] = ~ext_irq[i];
    irq_ack = irq_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    r = $urandom_range(0, 9);
    writeEnable = (r < 2);
    readEnable  = (r >= 2 && r < 5);
    case ($urandom_range(0, 3))
      0: address = A_MSIP;
      1: address = A_PEND;
      2: address = A_EN;
      default: address = A_BAD;
    endcase
    writeData       = $urandom;
    writeByteEnable = 4'($urandom_range(0, 15));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : directed
    logic [31:0] rd;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("reset irq_valid", 32'(irq_valid), 32'd0);
    checkOutput("reset irq_cause", 32'(irq_cause), 32'd0);
    checkOutput("reset irq_ext_id", 32'(irq_ext_id), 32'd0);
    checkOutput("reset readData", readData, 32'd0);

    // Timer request, ack gap, re-request while the timer stays high.
    mstatus_mie = 1; mie_msie = 1; mie_mtie = 1; mie_meie = 1; timer_interrupt = 1;
    tick();
    checkOutput("t1 valid", 32'(irq_valid), 32'd1);
    checkOutput("t1 cause", 32'(irq_cause), 32'd7);
    ackOnce();
    checkOutput("t1 ackd gap", 32'(irq_valid), 32'd0);
    tick();
    checkOutput("t1 idle", 32'(irq_valid), 32'd0);
    tick();
    checkOutput("t1 rerequest", 32'(irq_valid), 32'd1);
    timer_interrupt = 0;
    ackOnce();
    repeat (2) tick();
    checkOutput("t1 quiet", 32'(irq_valid), 32'd0);

    busWrite(A_EN, 32'h5, 4'hF);
    ext_irq = 4'b0100;
    tick();
    ext_irq = 4'b0000;
    waitValid("t2 valid");
    checkOutput("t2 cause", 32'(irq_cause), 32'd11);
    checkOutput("t2 id", 32'(irq_ext_id), 32'd2);
    busRead(A_PEND, rd);
    checkOutput("t2 pending", rd, 32'h4);
    ackOnce();
    busRead(A_PEND, rd);
    checkOutput("t2 pending after ack", rd, 32'h0);
    tick();

    timer_interrupt = 1;
    tick();
    checkOutput("t3 cause mti", 32'(irq_cause), 32'd7);
    busWrite(A_MSIP, 32'h1, 4'h1);
    checkOutput("t3 held valid", 32'(irq_valid), 32'd1);
    checkOutput("t3 held cause", 32'(irq_cause), 32'd7);
    ackOnce();
    repeat (2) tick();
    checkOutput("t3 msi valid", 32'(irq_valid), 32'd1);
    checkOutput("t3 msi cause", 32'(irq_cause), 32'd3);
    timer_interrupt = 0;
    busWrite(A_MSIP, 32'h0, 4'h1);
    tick();
    checkOutput("t3 dropped", 32'(irq_valid), 32'd0);

    busWrite(A_EN, 32'hF, 4'h1);
    ext_irq = 4'b1001;
    tick();
    ext_irq = 4'b0000;
    waitValid("t4 first valid");
    checkOutput("t4 first id", 32'(irq_ext_id), 32'd0);
    ackOnce();
    tick();
    waitValid("t4 second valid");
    checkOutput("t4 second cause", 32'(irq_cause), 32'd11);
    checkOutput("t4 second id", 32'(irq_ext_id), 32'd3);
    ackOnce();
    repeat (2) tick();

    ext_irq = 4'b0001;
    tick();
    ext_irq = 4'b0000;
    waitValid("t5 valid");
    checkOutput("t5 id", 32'(irq_ext_id), 32'd0);
    mstatus_mie = 0;
    tick();
    checkOutput("t5 drop", 32'(irq_valid), 32'd0);
    busRead(A_PEND, rd);
    checkOutput("t5 pending kept", rd, 32'h1);
    busWrite(A_PEND, 32'h1, 4'h1);
    busRead(A_PEND, rd);
    checkOutput("t5 w1c", rd, 32'h0);
    mstatus_mie = 1;

    // Pending capture latency observed through back-to-back pending reads.
    busWrite(A_EN, 32'h5, 4'h1);
    ext_irq = 4'b0010;
    address = A_PEND; readEnable = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("t6 pend k%0d", k), readData, (k - 1 >= SET_EDGE) ? 32'h2 : 32'h0);
    end
    readEnable = 0; ext_irq = 4'b0000;
    busWrite(A_PEND, 32'h2, 4'h1);
    busWrite(A_EN, 32'hA, 4'h0);
    busRead(A_EN, rd);
    checkOutput("t6 lane mask", rd, 32'h5);
    busRead(A_BAD, rd);
    checkOutput("t6 unmapped", rd, 32'h0);
    timer_interrupt = 1;
    tick();
    checkOutput("t6 req", 32'(irq_valid), 32'd1);
    reset = 1;
    tick();
    checkOutput("t6 reset drop", 32'(irq_valid), 32'd0);
    reset = 0; timer_interrupt = 0;
    tick();

    repeat (3000) begin
      applyStimulus();
      tick();
    end
    reset = 0; irq_ack = 0; readEnable = 0; writeEnable = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
